// File: rtl/reindeer_csr_access_seq_if.sv
// CSR file port: read/write strobes from the sequencer, read data and fault back from the CSR file.
interface reindeer_csr_access_seq_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 12;

  logic              csr_read_enable;
  logic [ADDR_W-1:0] csr_read_addr;
  logic              csr_read_valid;
  logic [XLEN-1:0]   csr_read_data;
  logic              csr_write_enable;
  logic [ADDR_W-1:0] csr_write_addr;
  logic [XLEN-1:0]   csr_write_data;
  logic              csr_fault;

  modport master (
    output csr_read_enable, csr_read_addr, csr_write_enable, csr_write_addr, csr_write_data,
    input  csr_read_valid, csr_read_data, csr_fault
  );

  modport slave (
    input  csr_read_enable, csr_read_addr, csr_write_enable, csr_write_addr, csr_write_data,
    output csr_read_valid, csr_read_data, csr_fault
  );
endinterface

// File: rtl/reindeer_csr_access_seq.sv
// Zicsr access sequencer: one instruction becomes an ordered CSR read, then write,
// with the read-modify-write merge done here; returns the old CSR value for rd.
module reindeer_csr_access_seq (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_index,
  input  logic [31:0] rs1_value,
  input  logic [4:0]  rd_index,
  reindeer_csr_access_seq_if.master csr,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        rd_write_enable,
  output logic [4:0]  rd_index_out,
  output logic [31:0] rd_data
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_CHK, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic              do_read_q, do_read_d;
  logic              do_write_q, do_write_d;
  logic [1:0]        tmo_q, tmo_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              rwe_q, rwe_d;
  logic [REG_W-1:0]  rd_idx_q, rd_idx_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;

  // Decode of the incoming instruction, used only on the accept cycle
  logic [XLEN-1:0] in_src;
  logic            in_do_read, in_do_write, in_illegal;
  always_comb begin
    in_src      = funct3[2] ? {27'd0, rs1_index} : rs1_value;
    in_do_read  = !((funct3[1:0] == 2'b01) && (rd_index == '0));
    in_do_write = (funct3[1:0] == 2'b01) || (rs1_index != '0);
    in_illegal  = (funct3[1:0] == 2'b00) || (in_do_write && (csr_addr[11:10] == 2'b11));
  end

  function automatic logic [XLEN-1:0] merge(input logic [1:0] op, input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] src);
    case (op)
      2'b10:   merge = old | src;
      2'b11:   merge = old & ~src;
      default: merge = src;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    do_read_d  = do_read_q;
    do_write_d = do_write_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    rwe_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d       = funct3[1:0];
        src_d      = in_src;
        do_read_d  = in_do_read;
        do_write_d = in_do_write;
        addr_d     = csr_addr;
        rd_idx_d   = rd_index;
        if (in_illegal) begin
          state_d   = DONE;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else if (in_do_read) begin
          state_d = RD_REQ;
          rd_en_d = 1'b1;
        end else begin
          state_d = WR_REQ;
          wr_en_d = 1'b1;
          wdata_d = in_src;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        tmo_d   = 2'd0;
      end
      RD_WAIT: begin
        if (csr.csr_read_valid) begin
          rd_data_d = csr.csr_read_data;
          if (csr.csr_fault) begin
            state_d   = DONE;
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end else if (do_write_q) begin
            state_d = WR_REQ;
            wr_en_d = 1'b1;
            wdata_d = merge(op_q, csr.csr_read_data, src_q);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rwe_d   = (rd_idx_q != '0);
          end
        end else if (tmo_q == 2'd3) begin
          state_d   = DONE;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else begin
          tmo_d = 2'(tmo_q + 2'd1);
        end
      end
      WR_REQ: state_d = WR_CHK;
      WR_CHK: begin
        state_d   = DONE;
        done_d    = 1'b1;
        illegal_d = csr.csr_fault;
        rwe_d     = !csr.csr_fault && do_read_q && (rd_idx_q != '0);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      src_q      <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      tmo_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      rwe_q      <= 1'b0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      do_read_q  <= do_read_d;
      do_write_q <= do_write_d;
      tmo_q      <= tmo_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      rwe_q      <= rwe_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // A strobe already queued for the cycle in which reset arrives never reaches the CSR file
  assign csr.csr_read_enable  = rd_en_q && !sync_reset;
  assign csr.csr_write_enable = wr_en_q && !sync_reset;
  assign csr.csr_read_addr    = addr_q;
  assign csr.csr_write_addr   = addr_q;
  assign csr.csr_write_data   = wdata_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign illegal              = illegal_q;
  assign rd_write_enable      = rwe_q;
  assign rd_index_out         = rd_idx_q;
  assign rd_data              = rd_data_q;
endmodule

// File: tb/tb_reindeer_csr_access_seq.sv
// Directed bench for reindeer_csr_access_seq with a one-cycle-latency CSR file responder.
module tb_reindeer_csr_access_seq;
  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_addr = '0;
  logic [4:0]  rs1_index = '0;
  logic [31:0] rs1_value = '0;
  logic [4:0]  rd_index = '0;
  logic        busy, done, illegal, rd_write_enable;
  logic [4:0]  rd_index_out;
  logic [31:0] rd_data;

  reindeer_csr_access_seq_if csr_bus();

  reindeer_csr_access_seq dut (
    .clk(clk), .sync_reset(sync_reset), .start(start), .funct3(funct3), .csr_addr(csr_addr),
    .rs1_index(rs1_index), .rs1_value(rs1_value), .rd_index(rd_index), .csr(csr_bus.master),
    .busy(busy), .done(done), .illegal(illegal), .rd_write_enable(rd_write_enable),
    .rd_index_out(rd_index_out), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // CSR file model configuration
  logic [31:0] csr_val  = '0;
  logic        fault_rd = 1'b0;
  logic        fault_wr = 1'b0;
  logic        no_resp  = 1'b0;

  always @(posedge clk) begin
    csr_bus.csr_read_valid <= csr_bus.csr_read_enable && !no_resp;
    csr_bus.csr_read_data  <= csr_bus.csr_read_enable ? csr_val : 32'd0;
    csr_bus.csr_fault      <= (csr_bus.csr_read_enable && fault_rd) ||
                              (csr_bus.csr_write_enable && fault_wr);
  end

  int checks = 0;
  int failures = 0;
  int both_strobes = 0;

  // Observations of one operation
  int          rd_cyc, wr_cyc, done_cyc, n_rd, n_wr;
  logic [31:0] wdata_s, rdata_s;
  logic [11:0] waddr_s, raddr_s;
  logic        ill_s, rwe_s, busy_after_rst;
  logic [4:0]  rdidx_s;

  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] v, input logic [4:0] rd, input int inj_cyc,
                        input int rst_cyc);
    rd_cyc = -1; wr_cyc = -1; done_cyc = -1; n_rd = 0; n_wr = 0;
    wdata_s = '0; rdata_s = '0; waddr_s = '0; raddr_s = '0;
    ill_s = 1'b0; rwe_s = 1'b0; rdidx_s = '0; busy_after_rst = 1'b1;
    @(negedge clk);
    funct3 = f3; csr_addr = a; rs1_index = r1; rs1_value = v; rd_index = rd; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      sync_reset = (c == rst_cyc);
      if (c == inj_cyc) begin
        start = 1'b1; funct3 = 3'b001; csr_addr = 12'h123; rs1_index = 5'd1;
        rs1_value = 32'h55; rd_index = 5'd0;
      end
      #1;
      if (csr_bus.csr_read_enable) begin
        n_rd++;
        if (rd_cyc < 0) begin rd_cyc = c; raddr_s = csr_bus.csr_read_addr; end
      end
      if (csr_bus.csr_write_enable) begin
        n_wr++;
        if (wr_cyc < 0) begin
          wr_cyc = c; wdata_s = csr_bus.csr_write_data; waddr_s = csr_bus.csr_write_addr;
        end
      end
      if (csr_bus.csr_read_enable && csr_bus.csr_write_enable) both_strobes++;
      if (rst_cyc > 0 && c == rst_cyc + 1) busy_after_rst = busy;
      if (done && done_cyc < 0) begin
        done_cyc = c; ill_s = illegal; rwe_s = rd_write_enable; rdata_s = rd_data;
        rdidx_s = rd_index_out;
      end
      if (done_cyc > 0 && inj_cyc == 0 && rst_cyc == 0) break;
    end
    start = 1'b0;
    sync_reset = 1'b0;
  endtask

  task automatic test_reset;
    sync_reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, illegal, rd_write_enable} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, illegal, rd_write_enable});
    end
    checks++;
    if ({csr_bus.csr_read_enable, csr_bus.csr_write_enable} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00",
                           {csr_bus.csr_read_enable, csr_bus.csr_write_enable});
    end
    checks++;
    if ({csr_bus.csr_read_addr, csr_bus.csr_write_addr, csr_bus.csr_write_data, rd_data, rd_index_out} !== '0) begin
      failures++; $display("FAIL reset_data raddr=%h waddr=%h wdata=%h rd_data=%h rd_idx=%0d exp=0",
                           csr_bus.csr_read_addr, csr_bus.csr_write_addr, csr_bus.csr_write_data,
                           rd_data, rd_index_out);
    end
    @(negedge clk);
    sync_reset = 1'b0;
  endtask

  task automatic test_rmw_rs;
    csr_val = 32'h0000_000F;
    run_op(3'b010, 12'h340, 5'd5, 32'h0000_00F0, 5'd7, 0, 0);
    checks++;
    if (rd_cyc !== 1 || raddr_s !== 12'h340) begin
      failures++; $display("FAIL rs_read cyc=%0d addr=%h exp cyc=1 addr=340", rd_cyc, raddr_s);
    end
    checks++;
    if (wr_cyc !== 3 || wdata_s !== 32'h0000_00FF || waddr_s !== 12'h340) begin
      failures++; $display("FAIL rs_write cyc=%0d data=%h addr=%h exp cyc=3 data=000000ff addr=340",
                           wr_cyc, wdata_s, waddr_s);
    end
    checks++;
    if (done_cyc !== 5 || ill_s !== 1'b0 || rwe_s !== 1'b1) begin
      failures++; $display("FAIL rs_done cyc=%0d ill=%b rwe=%b exp cyc=5 ill=0 rwe=1", done_cyc, ill_s, rwe_s);
    end
    checks++;
    if (rdata_s !== 32'h0000_000F || rdidx_s !== 5'd7) begin
      failures++; $display("FAIL rs_rd got data=%h idx=%0d exp data=0000000f idx=7", rdata_s, rdidx_s);
    end
  endtask

  task automatic test_rmw_rci;
    csr_val = 32'h0000_1888;
    run_op(3'b111, 12'h300, 5'd8, 32'hDEAD_BEEF, 5'd0, 0, 0);
    checks++;
    if (wr_cyc !== 3 || wdata_s !== 32'h0000_1880) begin
      failures++; $display("FAIL rci_write cyc=%0d data=%h exp cyc=3 data=00001880", wr_cyc, wdata_s);
    end
    checks++;
    if (done_cyc !== 5 || rwe_s !== 1'b0 || ill_s !== 1'b0) begin
      failures++; $display("FAIL rci_done cyc=%0d rwe=%b ill=%b exp cyc=5 rwe=0 ill=0", done_cyc, rwe_s, ill_s);
    end
  endtask

  task automatic test_write_only;
    run_op(3'b001, 12'h305, 5'd3, 32'h8000_0100, 5'd0, 0, 0);
    checks++;
    if (n_rd !== 0 || wr_cyc !== 1 || wdata_s !== 32'h8000_0100 || waddr_s !== 12'h305) begin
      failures++; $display("FAIL wo_write n_rd=%0d cyc=%0d data=%h addr=%h exp n_rd=0 cyc=1 data=80000100 addr=305",
                           n_rd, wr_cyc, wdata_s, waddr_s);
    end
    checks++;
    if (done_cyc !== 3 || rwe_s !== 1'b0 || ill_s !== 1'b0) begin
      failures++; $display("FAIL wo_done cyc=%0d rwe=%b ill=%b exp cyc=3 rwe=0 ill=0", done_cyc, rwe_s, ill_s);
    end
  endtask

  task automatic test_read_only;
    csr_val = 32'hABCD_1234;
    run_op(3'b010, 12'hF11, 5'd0, 32'hFFFF_FFFF, 5'd3, 0, 0);
    checks++;
    if (n_wr !== 0 || rd_cyc !== 1 || done_cyc !== 3) begin
      failures++; $display("FAIL ro_timing n_wr=%0d rd_cyc=%0d done=%0d exp 0/1/3", n_wr, rd_cyc, done_cyc);
    end
    checks++;
    if (rdata_s !== 32'hABCD_1234 || rwe_s !== 1'b1 || rdidx_s !== 5'd3) begin
      failures++; $display("FAIL ro_rd data=%h rwe=%b idx=%0d exp abcd1234/1/3", rdata_s, rwe_s, rdidx_s);
    end
    // Set-immediate with uimm 0 never writes, so a read-only CSR address is legal
    csr_val = 32'h0000_1234;
    run_op(3'b110, 12'hC00, 5'd0, 32'h0, 5'd9, 0, 0);
    checks++;
    if (n_wr !== 0 || done_cyc !== 3 || ill_s !== 1'b0 || rwe_s !== 1'b1 || rdata_s !== 32'h0000_1234) begin
      failures++; $display("FAIL rsi_ro n_wr=%0d done=%0d ill=%b rwe=%b data=%h exp 0/3/0/1/00001234",
                           n_wr, done_cyc, ill_s, rwe_s, rdata_s);
    end
  endtask

  task automatic test_illegal;
    run_op(3'b001, 12'hF14, 5'd1, 32'h1, 5'd2, 0, 0);
    checks++;
    if (done_cyc !== 1 || ill_s !== 1'b1 || n_rd !== 0 || n_wr !== 0 || rwe_s !== 1'b0) begin
      failures++; $display("FAIL ro_write done=%0d ill=%b n_rd=%0d n_wr=%0d rwe=%b exp 1/1/0/0/0",
                           done_cyc, ill_s, n_rd, n_wr, rwe_s);
    end
    run_op(3'b100, 12'h340, 5'd1, 32'h1, 5'd2, 0, 0);
    checks++;
    if (done_cyc !== 1 || ill_s !== 1'b1 || n_rd !== 0 || n_wr !== 0) begin
      failures++; $display("FAIL f3_100 done=%0d ill=%b n_rd=%0d n_wr=%0d exp 1/1/0/0", done_cyc, ill_s, n_rd, n_wr);
    end
    fault_rd = 1'b1;
    run_op(3'b010, 12'h7C0, 5'd4, 32'h3, 5'd6, 0, 0);
    fault_rd = 1'b0;
    checks++;
    if (done_cyc !== 3 || ill_s !== 1'b1 || n_wr !== 0 || rwe_s !== 1'b0) begin
      failures++; $display("FAIL rd_fault done=%0d ill=%b n_wr=%0d rwe=%b exp 3/1/0/0", done_cyc, ill_s, n_wr, rwe_s);
    end
    fault_wr = 1'b1;
    run_op(3'b101, 12'h340, 5'd3, 32'h0, 5'd0, 0, 0);
    fault_wr = 1'b0;
    checks++;
    if (wr_cyc !== 1 || wdata_s !== 32'd3 || done_cyc !== 3 || ill_s !== 1'b1) begin
      failures++; $display("FAIL wr_fault wr=%0d data=%h done=%0d ill=%b exp 1/00000003/3/1",
                           wr_cyc, wdata_s, done_cyc, ill_s);
    end
    no_resp = 1'b1;
    run_op(3'b010, 12'h341, 5'd0, 32'h0, 5'd4, 0, 0);
    no_resp = 1'b0;
    checks++;
    if (done_cyc !== 6 || ill_s !== 1'b1 || rwe_s !== 1'b0 || n_wr !== 0) begin
      failures++; $display("FAIL timeout done=%0d ill=%b rwe=%b n_wr=%0d exp 6/1/0/0", done_cyc, ill_s, rwe_s, n_wr);
    end
  endtask

  task automatic test_back_to_back;
    csr_val = 32'h0000_0001;
    run_op(3'b001, 12'h340, 5'd2, 32'h0000_0022, 5'd1, 0, 0);
    run_op(3'b010, 12'h341, 5'd0, 32'h0, 5'd11, 0, 0);
    checks++;
    if (done_cyc !== 3 || rdata_s !== 32'h0000_0001 || rdidx_s !== 5'd11 || rwe_s !== 1'b1) begin
      failures++; $display("FAIL b2b done=%0d data=%h idx=%0d rwe=%b exp 3/00000001/11/1",
                           done_cyc, rdata_s, rdidx_s, rwe_s);
    end
  endtask

  task automatic test_busy_start;
    csr_val = 32'h0000_000F;
    run_op(3'b010, 12'h340, 5'd5, 32'h0000_00F0, 5'd7, 2, 0);
    checks++;
    if (n_rd !== 1 || n_wr !== 1 || waddr_s !== 12'h340 || wdata_s !== 32'h0000_00FF || done_cyc !== 5) begin
      failures++; $display("FAIL busy_start_wait n_rd=%0d n_wr=%0d addr=%h data=%h done=%0d exp 1/1/340/000000ff/5",
                           n_rd, n_wr, waddr_s, wdata_s, done_cyc);
    end
    run_op(3'b010, 12'h340, 5'd5, 32'h0000_00F0, 5'd7, 5, 0);
    checks++;
    if (n_rd !== 1 || n_wr !== 1 || waddr_s !== 12'h340 || done_cyc !== 5) begin
      failures++; $display("FAIL busy_start_done n_rd=%0d n_wr=%0d addr=%h done=%0d exp 1/1/340/5",
                           n_rd, n_wr, waddr_s, done_cyc);
    end
  endtask

  task automatic test_reset_mid;
    csr_val = 32'h0000_000F;
    run_op(3'b010, 12'h340, 5'd5, 32'h0000_00F0, 5'd7, 0, 3);
    checks++;
    if (n_rd !== 1 || n_wr !== 0 || done_cyc !== -1) begin
      failures++; $display("FAIL rst_mid n_rd=%0d n_wr=%0d done=%0d exp 1/0/-1", n_rd, n_wr, done_cyc);
    end
    checks++;
    if (busy_after_rst !== 1'b0 || rd_data !== 32'd0 || rd_write_enable !== 1'b0) begin
      failures++; $display("FAIL rst_mid_state busy=%b rd_data=%h rwe=%b exp 0/00000000/0",
                           busy_after_rst, rd_data, rd_write_enable);
    end
  endtask

  initial begin
    test_reset();
    test_rmw_rs();
    test_rmw_rci();
    test_write_only();
    test_read_only();
    test_illegal();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    checks++;
    if (both_strobes !== 0) begin
      failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_strobes);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
